display_scheduler: RTL and testbench

- Owns the 4-digit seven-segment display path and decides which 11-bit two's-complement value goes to the digit-multiplexing stage.
- Three sources share the display:
  - the running credit balance (background, always available),
  - a bet amount (timed overlay),
  - a win amount (timed, blinking, highest priority).
- Sits between the game FSM and the display number/segment-mux block. Its outputs are registered.

---
 rtl/display_scheduler.sv | 168 ++++++++++++++++
 tb/tb_display_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Chooses which two's-complement value drives the 4-digit seven-segment path.
// Three sources share the display, lowest to highest priority:
//   credit - live balance, shown whenever no overlay is active
//   bet    - timed overlay, HOLD_TICKS tick pulses long
//   win    - timed, blinking overlay; may hold one bet pending behind it
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   tick         one-cycle timing strobe; all hold and blink timing counts these
//   credit       live credit balance
//   bet_req      one-cycle pulse: show bet_val
//   bet_val      bet amount, sampled only when bet_req=1
//   win_req      one-cycle pulse: show win_val
//   win_val      win amount, sampled only when win_req=1
//   clear        abort all overlays and drop any pending bet
//   disp_number  registered value to display
//   disp_blank   registered blank flag (blink off phase of a win)
//   disp_src     registered source code: 0 credit, 1 bet, 2 win
//   busy         registered: overlay shown or bet pending
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int WIDTH       = 11,
  parameter int HOLD_TICKS  = 4,
  parameter int BLINK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic signed [WIDTH-1:0] credit,
  input  logic                    bet_req,
  input  logic signed [WIDTH-1:0] bet_val,
  input  logic                    win_req,
  input  logic signed [WIDTH-1:0] win_val,
  input  logic                    clear,
  output logic signed [WIDTH-1:0] disp_number,
  output logic                    disp_blank,
  output logic [1:0]              disp_src,
  output logic                    busy
);

  localparam logic [1:0] CREDIT = 2'd0;
  localparam logic [1:0] BET    = 2'd1;
  localparam logic [1:0] WIN    = 2'd2;

  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_TICKS);
  localparam logic [7:0] BLINK_INIT = 8'(BLINK_TICKS);

  logic [1:0]              state;
  logic [7:0]              hold_cnt;
  logic [7:0]              blink_cnt;
  logic                    pending;
  logic signed [WIDTH-1:0] bet_lat;
  logic signed [WIDTH-1:0] win_lat;

  logic [1:0]              state_nxt;
  logic [7:0]              hold_nxt;
  logic [7:0]              blink_nxt;
  logic                    pending_nxt;
  logic                    blank_nxt;
  logic signed [WIDTH-1:0] bet_nxt;
  logic signed [WIDTH-1:0] win_nxt;
  logic signed [WIDTH-1:0] number_nxt;
  logic                    advance;

  // Next-state decision: requests first, then tick-driven timing
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    blink_nxt   = blink_cnt;
    pending_nxt = pending;
    blank_nxt   = disp_blank;
    bet_nxt     = bet_lat;
    win_nxt     = win_lat;
    advance     = 1'b0;

    if (clear) begin
      state_nxt   = CREDIT;
      pending_nxt = 1'b0;
      blank_nxt   = 1'b0;
    end else if (win_req) begin
      // Entering or restarting WIN; an interrupted bet is simply dropped.
      win_nxt   = win_val;
      state_nxt = WIN;
      hold_nxt  = HOLD_INIT;
      blink_nxt = BLINK_INIT;
      blank_nxt = 1'b0;
      if (bet_req) begin
        bet_nxt     = bet_val;
        pending_nxt = 1'b1;
      end
    end else if (bet_req && state != WIN) begin
      bet_nxt   = bet_val;
      state_nxt = BET;
      hold_nxt  = HOLD_INIT;
      blank_nxt = 1'b0;
    end else begin
      // A bet arriving during WIN is queued; WIN timing keeps running.
      if (bet_req) begin
        bet_nxt     = bet_val;
        pending_nxt = 1'b1;
      end
      advance = 1'b1;
    end

    if (advance && tick && state != CREDIT) begin
      if (hold_cnt == 8'd1) begin
        // Overlay expires. A bet queued this very cycle is still honoured,
        // so it can never be left pending while CREDIT is shown.
        blank_nxt = 1'b0;
        if (state == WIN && pending_nxt) begin
          state_nxt   = BET;
          hold_nxt    = HOLD_INIT;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = CREDIT;
        end
      end else begin
        hold_nxt = hold_cnt - 8'd1;
        if (state == WIN) begin
          if (blink_cnt == 8'd1) begin
            blink_nxt = BLINK_INIT;
            blank_nxt = ~disp_blank;
          end else begin
            blink_nxt = blink_cnt - 8'd1;
          end
        end
      end
    end

    case (state_nxt)
      BET:     number_nxt = bet_nxt;
      WIN:     number_nxt = win_nxt;
      default: number_nxt = credit;
    endcase
  end

  // Register stage: state, counters, latched values and all outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CREDIT;
      hold_cnt    <= 8'd0;
      blink_cnt   <= 8'd0;
      pending     <= 1'b0;
      bet_lat     <= '0;
      win_lat     <= '0;
      disp_number <= '0;
      disp_blank  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      blink_cnt   <= blink_nxt;
      pending     <= pending_nxt;
      bet_lat     <= bet_nxt;
      win_lat     <= win_nxt;
      disp_number <= number_nxt;
      disp_blank  <= blank_nxt;
      busy        <= (state_nxt != CREDIT) || pending_nxt;
    end
  end

  assign disp_src = state;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Directed scenarios followed by randomized traffic, every cycle compared
// against a reference model that tracks the display as "which overlay is up
// and how many ticks it has been up", with blank derived from elapsed ticks.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

  localparam int W     = 11;
  localparam int HOLD  = 4;
  localparam int BLINK = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [W-1:0]  credit;
  logic          bet_req;
  logic [W-1:0]  bet_val;
  logic          win_req;
  logic [W-1:0]  win_val;
  logic          clear;
  logic [W-1:0]  disp_number;
  logic          disp_blank;
  logic [1:0]    disp_src;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           m_mode;   // 0 credit, 1 bet, 2 win
  int           m_seen;   // ticks counted since the current overlay began
  bit           m_pend;
  logic [W-1:0] m_bet;
  logic [W-1:0] m_win;
  logic [W-1:0] m_num;
  bit           m_blank;
  bit           m_busy;

  display_scheduler #(
    .WIDTH(W),
    .HOLD_TICKS(HOLD),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .credit(credit),
    .bet_req(bet_req),
    .bet_val(bet_val),
    .win_req(win_req),
    .win_val(win_val),
    .clear(clear),
    .disp_number(disp_number),
    .disp_blank(disp_blank),
    .disp_src(disp_src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_seen = 0; m_pend = 0;
      m_bet = '0; m_win = '0;
    end else if (clear) begin
      m_mode = 0; m_pend = 0;
    end else if (win_req) begin
      m_win = win_val; m_mode = 2; m_seen = 0;
      if (bet_req) begin m_bet = bet_val; m_pend = 1; end
    end else if (bet_req && m_mode != 2) begin
      m_bet = bet_val; m_mode = 1; m_seen = 0;
    end else begin
      if (bet_req) begin m_bet = bet_val; m_pend = 1; end
      if (tick && m_mode != 0) begin
        m_seen++;
        if (m_seen == HOLD) begin
          if (m_mode == 2 && m_pend) begin
            m_mode = 1; m_seen = 0; m_pend = 0;
          end else begin
            m_mode = 0;
          end
        end
      end
    end
    m_blank = (m_mode == 2) ? (((m_seen / BLINK) % 2) == 1) : 1'b0;
    if (!rst_n)           m_num = '0;
    else if (m_mode == 0) m_num = credit;
    else if (m_mode == 1) m_num = m_bet;
    else                  m_num = m_win;
    m_busy = (m_mode != 0) || m_pend;
  endtask

  // One clock: drive inputs, step model, sample after the edge, compare.
  task automatic cyc(input bit r, input bit t, input bit br, input logic [W-1:0] bv,
                     input bit wr, input logic [W-1:0] wv, input bit cl,
                     input logic [W-1:0] cr);
    rst_n = r; tick = t; bet_req = br; bet_val = bv;
    win_req = wr; win_val = wv; clear = cl; credit = cr;
    model_step();
    @(posedge clk);
    #1;
    check_val("number", 32'(disp_number), 32'(m_num));
    check_val("src",    32'(disp_src),    32'(m_mode));
    check_val("blank",  32'(disp_blank),  32'(m_blank));
    check_val("busy",   32'(busy),        32'(m_busy));
  endtask

  task automatic idle(input logic [W-1:0] cr);
    cyc(1, 0, 0, '0, 0, '0, 0, cr);
  endtask

  task automatic tk(input logic [W-1:0] cr);
    cyc(1, 1, 0, '0, 0, '0, 0, cr);
  endtask

  initial begin
    rst_n = 0; tick = 0; bet_req = 0; bet_val = '0;
    win_req = 0; win_val = '0; clear = 0; credit = 11'd250;

    // Reset then idle
    cyc(0, 0, 0, '0, 0, '0, 0, 11'd250);
    cyc(0, 0, 0, '0, 0, '0, 0, 11'd250);
    check_val("rst_number", 32'(disp_number), 32'd0);
    idle(11'd250);
    check_val("idle_number", 32'(disp_number), 32'd250);
    idle(11'd251);

    // Bet overlay
    cyc(1, 0, 1, 11'd5, 0, '0, 0, 11'd251);
    check_val("bet_src", 32'(disp_src), 32'd1);
    check_val("bet_number", 32'(disp_number), 32'd5);
    for (int i = 0; i < HOLD; i++) begin
      tk(11'd252);
      idle(11'd252);
    end
    check_val("bet_end_src", 32'(disp_src), 32'd0);
    check_val("bet_end_number", 32'(disp_number), 32'd252);

    // Win blink
    cyc(1, 0, 0, '0, 1, 11'd100, 0, 11'd252);
    check_val("win_blank0", 32'(disp_blank), 32'd0);
    for (int i = 0; i < HOLD; i++) begin
      tk(11'd252);
      idle(11'd252);
    end
    check_val("win_end_src", 32'(disp_src), 32'd0);
    check_val("win_end_blank", 32'(disp_blank), 32'd0);

    // Simultaneous bet and win
    cyc(1, 0, 1, 11'h7FE, 1, 11'd40, 0, 11'd252);
    check_val("sim_win", 32'(disp_number), 32'd40);
    for (int i = 0; i < HOLD; i++) tk(11'd252);
    check_val("sim_bet", 32'(disp_number), 32'h7FE);
    check_val("sim_busy", 32'(busy), 32'd1);
    for (int i = 0; i < HOLD; i++) tk(11'd253);
    check_val("sim_done_busy", 32'(busy), 32'd0);

    // Preemption of a bet by a win
    cyc(1, 0, 1, 11'd3, 0, '0, 0, 11'd253);
    tk(11'd253);
    cyc(1, 0, 0, '0, 1, 11'd7, 0, 11'd253);
    for (int i = 0; i < HOLD; i++) tk(11'd254);
    check_val("preempt_src", 32'(disp_src), 32'd0);

    // Win restart after 2 ticks
    cyc(1, 0, 0, '0, 1, 11'd8, 0, 11'd254);
    tk(11'd254);
    tk(11'd254);
    cyc(1, 1, 0, '0, 1, 11'd9, 0, 11'd254);
    check_val("restart_number", 32'(disp_number), 32'd9);
    check_val("restart_blank", 32'(disp_blank), 32'd0);
    for (int i = 0; i < HOLD - 1; i++) tk(11'd254);
    check_val("restart_still_win", 32'(disp_src), 32'd2);
    tk(11'd254);

    // Clear during win with a pending bet
    cyc(1, 0, 1, 11'd11, 1, 11'd12, 0, 11'd255);
    cyc(1, 0, 0, '0, 0, '0, 1, 11'd255);
    check_val("clear_busy", 32'(busy), 32'd0);
    check_val("clear_src", 32'(disp_src), 32'd0);

    // Reset during bet
    cyc(1, 0, 1, 11'd20, 0, '0, 0, 11'd255);
    cyc(0, 0, 0, '0, 0, '0, 0, 11'd255);
    check_val("midrst_number", 32'(disp_number), 32'd0);
    idle(11'd100);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 11) == 0), W'($urandom),
          ($urandom_range(0, 19) == 0), W'($urandom),
          ($urandom_range(0, 59) == 0),
          W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
